// File: rtl/seg_pkg.sv
// Shared 7-segment encodings (active high, bit6=a .. bit0=g) and the BCD decode
// used by the scanning driver and the static decoder; pure combinational helpers.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b111_1110;
    localparam logic [6:0] SEG_1     = 7'b011_0000;
    localparam logic [6:0] SEG_2     = 7'b110_1101;
    localparam logic [6:0] SEG_3     = 7'b111_1001;
    localparam logic [6:0] SEG_4     = 7'b011_0011;
    localparam logic [6:0] SEG_5     = 7'b101_1011;
    localparam logic [6:0] SEG_6     = 7'b001_1111;
    localparam logic [6:0] SEG_7     = 7'b111_0000;
    localparam logic [6:0] SEG_8     = 7'b111_1111;
    localparam logic [6:0] SEG_9     = 7'b111_0011;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Codes 10-15 are not digits and show nothing.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Signal bundle between the countdown timer and seg_scan_driver; blink exists only with SEG_BLINK_EN.
// Pure wiring: no latency; no backpressure, the display side free-runs.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 3
);
    logic [4*NUM_DIGITS-1:0] digits_bcd;
    logic                    load;
    logic                    lzb_en;
`ifdef SEG_BLINK_EN
    logic                    blink;
`endif
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   dig_sel;

`ifdef SEG_BLINK_EN
    modport master (output digits_bcd, load, lzb_en, blink, input seg_out, dig_sel);
    modport slave  (input digits_bcd, load, lzb_en, blink, output seg_out, dig_sel);
`else
    modport master (output digits_bcd, load, lzb_en, input seg_out, dig_sel);
    modport slave  (input digits_bcd, load, lzb_en, output seg_out, dig_sel);
`endif

endinterface

// File: rtl/seg_prescaler.sv
// Free-running divider: counts enabled cycles 0..DIV-1 and pulses tick on the terminal count.
// Tick is combinational from the count (same cycle); no backpressure, en simply pauses the count.
module seg_prescaler #(
    parameter int unsigned DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CW'(DIV - 1));
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed BCD 7-segment scanner with leading-zero blanking; SEG_BLINK_EN adds frame-based blinking.
// Outputs registered (1 clock from index/shadow, 2 clocks load-to-visible); no backpressure.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int KEEP_LSD     = 0,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [IW-1:0]           index_q, index_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    zero_run;
    logic [3:0]              cur_bcd;
    logic                    cur_blank;
    logic                    scan_tick;
    logic                    frame_wrap;
    logic                    blink_off;

    seg_prescaler #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .tick  (scan_tick)
    );

    assign frame_wrap = scan_tick && (index_q == IW'(NUM_DIGITS - 1));

`ifdef SEG_BLINK_EN
    logic frame_tick;
    logic phase_q, phase_d;

    seg_prescaler #(.DIV(BLINK_FRAMES)) u_blink_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (frame_wrap),
        .tick  (frame_tick)
    );

    always_comb begin
        phase_d = phase_q ^ frame_tick;
    end

    // phase_q = 1 means segments visible; blinking starts in the visible half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign blink_off = bus.blink && !phase_q;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES == 0);
    assign blink_off        = 1'b0;
`endif

    // lead_zero[i]: every digit from the top down to i is a literal zero code.
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (shadow_q[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end

    always_comb begin
        shadow_d = bus.load ? bus.digits_bcd : shadow_q;
        index_d  = index_q;
        if (frame_wrap) begin
            index_d = '0;
        end else if (scan_tick) begin
            index_d = index_q + 1'b1;
        end

        cur_bcd   = 4'd0;
        cur_blank = 1'b0;
        sel_d     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_q == IW'(i)) begin
                cur_bcd   = shadow_q[4*i +: 4];
                cur_blank = bus.lzb_en && lead_zero[i] && !((KEEP_LSD != 0) && (i == 0));
                sel_d[i]  = 1'b1;
            end
        end
        // Blanked digits keep their enable so every digit gets the same scan duty.
        seg_d = (cur_blank || blink_off) ? SEG_BLANK : bcd_to_seg(cur_bcd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            index_q  <= '0;
            seg_q    <= SEG_BLANK;
            sel_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            index_q  <= index_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.seg_out = seg_q;
    assign bus.dig_sel = sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed test-plan steps plus random loads, every cycle
// compared with an arithmetic reference model of the scan position, blanking and blink.
module tb_seg_scan_driver;

    localparam int N    = 3;
    localparam int DIV  = 4;
    localparam int KEEP = 0;
    localparam int BF   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    logic [4*N-1:0] din = '0;
    logic           ld  = 1'b0;
    logic           lzb = 1'b0;
    assign bus.digits_bcd = din;
    assign bus.load       = ld;
    assign bus.lzb_en     = lzb;
`ifdef SEG_BLINK_EN
    logic blk = 1'b0;
    assign bus.blink = blk;
`endif

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .KEEP_LSD     (KEEP),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since reset release and the latched value.
    int             k    = 0;
    logic [4*N-1:0] m_sh = '0;
    logic [6:0]     cap [0:N-1];

    logic [6:0] tbl [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011};

    function automatic logic [6:0] exp_seg(input logic [4*N-1:0] sh, input int idx,
                                           input bit lz, input bit bl, input int kk);
        logic [4*N-1:0] hi;
        logic [3:0]     d;
        hi = sh >> (4 * idx);
        d  = hi[3:0];
        if (lz && !(KEEP != 0 && idx == 0) && hi == '0) return 7'b0;
        if (bl && ((((kk - 1) / (DIV * N)) / BF) % 2) == 1) return 7'b0;
        if (d > 4'd9) return 7'b0;
        return tbl[d];
    endfunction

    task automatic chk7(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag);
        bit             lz_c, ld_c, b_c;
        logic [4*N-1:0] d_c;
        logic [6:0]     es;
        logic [N-1:0]   esel;
        int             idx;
        lz_c = lzb;
        ld_c = ld;
        d_c  = din;
        b_c  = 1'b0;
`ifdef SEG_BLINK_EN
        b_c  = blk;
`endif
        @(posedge clk);
        #1;
        k++;
        idx  = ((k - 1) / DIV) % N;
        es   = exp_seg(m_sh, idx, lz_c, b_c, k);
        esel = '0;
        esel[idx] = 1'b1;
        if (ld_c) m_sh = d_c;
        chk7({tag, "_seg"}, bus.seg_out, es);
        chkn({tag, "_sel"}, bus.dig_sel, esel);
        cap[idx] = bus.seg_out;
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        din = v;
        ld  = 1'b1;
        step("load");
        ld  = 1'b0;
    endtask

    // Settle one frame, then capture the next frame and compare with literal segment codes.
    task automatic frame_check(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                               input logic [6:0] e0);
        repeat (N * DIV) step(tag);
        repeat (N * DIV) step(tag);
        chk7({tag, "_d2"}, cap[2], e2);
        chk7({tag, "_d1"}, cap[1], e1);
        chk7({tag, "_d0"}, cap[0], e0);
    endtask

    function automatic logic [4*N-1:0] rnd_bcd();
        logic [4*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1. Reset state and scan wrap.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk7("rst_seg", bus.seg_out, 7'b0);
            chkn("rst_sel", bus.dig_sel, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        m_sh  = '0;
        repeat (N * DIV + 1) step("wrap");
        chkn("wrap_back", bus.dig_sel, 3'b001);

        // 2. Basic decode.
        lzb = 1'b1;
        do_load(12'h125);
        frame_check("dec125", 7'b0110000, 7'b1101101, 7'b1011011);

        // 3. Leading-zero blanking.
        do_load(12'h005);
        frame_check("lz005", 7'b0, 7'b0, 7'b1011011);
        do_load(12'h105);
        frame_check("lz105", 7'b0110000, 7'b1111110, 7'b1011011);
        do_load(12'h000);
        frame_check("lz000", 7'b0, 7'b0, 7'b0);
        lzb = 1'b0;
        frame_check("nolz000", 7'b1111110, 7'b1111110, 7'b1111110);

        // 4. Invalid codes.
        lzb = 1'b1;
        do_load(12'h1A3);
        frame_check("inv1A3", 7'b0110000, 7'b0, 7'b1111001);
        do_load(12'h0A0);
        frame_check("inv0A0", 7'b0, 7'b0, 7'b1111110);

`ifdef SEG_BLINK_EN
        // 5. Blink: visible/blank halves of BF frames each, dig_sel keeps scanning.
        blk = 1'b1;
        do_load(12'h888);
        repeat (4 * BF * N * DIV) step("blink");
        blk = 1'b0;
        repeat (N * DIV) step("unblink");
`endif

        // Random loads, blanking enables and blink requests against the model.
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                din = rnd_bcd();
                ld  = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) lzb = 1'($urandom_range(0, 1));
`ifdef SEG_BLINK_EN
            if ($urandom_range(0, 29) == 0) blk = 1'($urandom_range(0, 1));
`endif
            step("rand");
            ld = 1'b0;
        end

        // 6. Async reset in the middle of the digit-1 slot.
        lzb = 1'b1;
        do_load(12'h456);
        for (int g = 0; g < 2 * N * DIV; g++) begin
            if ((((k - 1) / DIV) % N) == 1 && ((k - 1) % DIV) == 1) break;
            step("seek");
        end
        chkn("pre_rst_sel", bus.dig_sel, 3'b010);
        rst_n = 1'b0;
        #1;
        chk7("async_rst_seg", bus.seg_out, 7'b0);
        chkn("async_rst_sel", bus.dig_sel, '0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk7("hold_rst_seg", bus.seg_out, 7'b0);
            chkn("hold_rst_sel", bus.dig_sel, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        m_sh  = '0;
        step("restart");
        chkn("restart_sel", bus.dig_sel, 3'b001);
        frame_check("restart", 7'b0, 7'b0, 7'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
